// File: rtl/source_controller_pkg.sv
// Shared AHB2AHB bridge definitions: FSM encodings, packet widths and field
// offsets for the default bridge configuration.
package source_controller_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int PKT_W_DEF  = ADDR_W_DEF + DATA_W_DEF + 2;
    localparam int RSP_W_DEF  = DATA_W_DEF + 1;
    localparam int MAX_OUT_DEF = 4;

    localparam int RW_BIT    = PKT_W_DEF - 1;
    localparam int VALID_BIT = PKT_W_DEF - 2;
    localparam int ADDR_LSB  = DATA_W_DEF;

    typedef logic [1:0] state_t;

    localparam state_t ST_NORMAL = 2'b00;
    localparam state_t ST_DRAIN  = 2'b01;
    localparam state_t ST_IDLE   = 2'b11;

    function automatic int cnt_width(input int max_count);
        return $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/source_controller_outstanding_counter.sv
// Up/down count of reads in flight; increments and decrements are ignored at
// the limit and at zero respectively, so the count can never wrap.
module outstanding_counter #(
    parameter int MAX_COUNT = 4,
    parameter int CW        = source_controller_pkg::cnt_width(MAX_COUNT)
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic at_limit_o
);

    localparam logic [CW-1:0] LIMIT = CW'(MAX_COUNT);

    logic [CW-1:0] count_q, count_d;
    logic          inc_ok, dec_ok;

    assign zero_o     = (count_q == '0);
    assign at_limit_o = (count_q == LIMIT);
    assign inc_ok     = inc_i && !at_limit_o;
    assign dec_ok     = dec_i && !zero_o;

    always_comb begin
        count_d = count_q;
        case ({inc_ok, dec_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) count_q <= '0;
        else          count_q <= count_d;
    end

endmodule

// File: rtl/source_controller.sv
// Source-domain side of the AHB2AHB bridge: request packing, read-response
// return and the source half of the sleep handshake.
//   state  | meaning
//   NORMAL | accepting requests, returning responses
//   DRAIN  | sleep requested; no new requests, waiting for traffic to finish
//   IDLE   | all traffic drained; sleep status/ack reported
module source_controller
    import source_controller_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_W_DEF,
    parameter int DATA_WIDTH      = DATA_W_DEF,
    parameter int packet_width    = ADDR_WIDTH + DATA_WIDTH + 2,
    parameter int MAX_OUTSTANDING = MAX_OUT_DEF
) (
    input  logic                    i_clk_source,
    input  logic                    i_rstn_source,
    input  logic                    i_source_sleep_req,
    input  logic                    sink_sleep_status,
    input  logic                    i_valid,
    input  logic                    i_rd0_wr1,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    output logic                    o_ready,
    output logic [DATA_WIDTH-1:0]   o_rd_data,
    output logic                    o_rd_valid,
    input  logic                    req_fifo_full,
    input  logic                    req_fifo_empty,
    input  logic                    rsp_fifo_empty,
    input  logic [DATA_WIDTH:0]     i_rsp_packet,
    output logic [packet_width-1:0] o_req_packet,
    output logic                    req_fifo_wr_en,
    output logic                    rsp_fifo_rd_en,
    output logic                    o_source_sleep_ack,
    output logic                    source_sleep_status
);

    localparam int RW_POS    = packet_width - 1;
    localparam int VALID_POS = packet_width - 2;
    localparam int ADDR_POS  = DATA_WIDTH;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q, ack_q, status_q;
    logic                  accept, cnt_zero, cnt_at_limit;

    assign o_ready = (state_q == ST_NORMAL) && !req_fifo_full && !sink_sleep_status
                     && !cnt_at_limit;
    assign accept         = i_valid && o_ready;
    assign req_fifo_wr_en = accept;
    assign rsp_fifo_rd_en = !rsp_fifo_empty && !cnt_zero && (state_q != ST_IDLE);

    // Write data field is zeroed for reads so the sink never sees stale data.
    always_comb begin
        o_req_packet = '0;
        if (accept) begin
            o_req_packet[RW_POS]                  = i_rd0_wr1;
            o_req_packet[VALID_POS]               = 1'b1;
            o_req_packet[ADDR_POS +: ADDR_WIDTH]  = i_addr;
            o_req_packet[0 +: DATA_WIDTH]         = i_rd0_wr1 ? i_wr_data : '0;
        end
    end

    outstanding_counter #(
        .MAX_COUNT (MAX_OUTSTANDING)
    ) u_outstanding (
        .clk_i      (i_clk_source),
        .rst_n_i    (i_rstn_source),
        .inc_i      (accept && !i_rd0_wr1),
        .dec_i      (rsp_fifo_rd_en),
        .zero_o     (cnt_zero),
        .at_limit_o (cnt_at_limit)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_NORMAL: if (i_source_sleep_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (cnt_zero && req_fifo_empty && rsp_fifo_empty) state_d = ST_IDLE;
            ST_IDLE:   if (!i_source_sleep_req) state_d = ST_NORMAL;
            default:   state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge i_clk_source or negedge i_rstn_source) begin
        if (!i_rstn_source) begin
            state_q    <= ST_NORMAL;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            ack_q      <= 1'b0;
            status_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_valid_q <= rsp_fifo_rd_en && i_rsp_packet[DATA_WIDTH];
            if (rsp_fifo_rd_en) rd_data_q <= i_rsp_packet[DATA_WIDTH-1:0];
            status_q   <= (state_q == ST_IDLE);
            ack_q      <= (state_q == ST_IDLE) && i_source_sleep_req;
        end
    end

    assign o_rd_data           = rd_data_q;
    assign o_rd_valid          = rd_valid_q;
    assign o_source_sleep_ack  = ack_q;
    assign source_sleep_status = status_q;

endmodule

// File: doc/source_controller.md
# source_controller

Source-side control block of the AHB2AHB bridge, running in the source clock domain. It accepts read/write requests from the source slave interface, packs them into 66-bit request packets for the request FIFO, and pops 33-bit response packets from the response FIFO to return read data. It also owns the source half of the sleep handshake and drains all in-flight traffic before reporting sleep status to the sink side.

## Interface
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, data width
- packet_width, 66, request packet width; equals ADDR_WIDTH+DATA_WIDTH+2
- MAX_OUTSTANDING, 4, maximum reads in flight (1..15)

- i_clk_source  in  1  single clock for the whole block
- i_rstn_source  in  1  reset; asynchronous, active-low
- i_source_sleep_req  in  1  sleep request from the source power controller
- sink_sleep_status  in  1  sink side is idle or asleep
- i_valid  in  1  slave-side request valid
- i_rd0_wr1  in  1  request direction: 0 read, 1 write
- i_addr  in  ADDR_WIDTH  request address
- i_wr_data  in  DATA_WIDTH  write data
- o_ready  out  1  request accepted this cycle when high with i_valid
- o_rd_data  out  DATA_WIDTH  returned read data
- o_rd_valid  out  1  o_rd_data valid, one-cycle pulse
- req_fifo_full  in  1  request FIFO full
- req_fifo_empty  in  1  request FIFO empty
- rsp_fifo_empty  in  1  response FIFO empty
- i_rsp_packet  in  DATA_WIDTH+1  response FIFO head word {rd_valid, rd_data}, show-ahead
- o_req_packet  out  packet_width  request packet {rd0_wr1, valid, addr, wr_data}
- req_fifo_wr_en  out  1  request FIFO push
- rsp_fifo_rd_en  out  1  response FIFO pop
- o_source_sleep_ack  out  1  sleep acknowledge
- source_sleep_status  out  1  source side idle

## Operation
- FSM states: NORMAL (2'b00), DRAIN (2'b01), IDLE (2'b11).
- NORMAL → DRAIN when i_source_sleep_req; DRAIN → IDLE when outstanding==0 && req_fifo_empty && rsp_fifo_empty; IDLE → NORMAL when !i_source_sleep_req. The other direction holds.
- sink_sleep_status does not change state. In NORMAL it only forces o_ready low.
- o_ready (combinational) = NORMAL && !req_fifo_full && !sink_sleep_status && (outstanding < MAX_OUTSTANDING).
- Accept = i_valid && o_ready.
  - req_fifo_wr_en = accept.
  - o_req_packet = {i_rd0_wr1, 1'b1, i_addr, i_rd0_wr1 ? i_wr_data : 0}; all zeros when not accepting.
- Outstanding counter, width clog2(MAX_OUTSTANDING+1):
  - +1 on an accepted read; −1 on a response pop.
  - Simultaneous increment and decrement leaves it unchanged.
  - Never wraps: o_ready prevents overflow, and a pop requires outstanding>0.
- rsp_fifo_rd_en (combinational) = !rsp_fifo_empty && outstanding>0 && state != IDLE.
- Response pop registers o_rd_data = i_rsp_packet[DATA_WIDTH-1:0] and o_rd_valid = i_rsp_packet[DATA_WIDTH] on the next edge. Otherwise o_rd_valid=0 and o_rd_data holds its value.
- A response with rd_valid=0 is popped and decrements the counter, but produces no o_rd_valid.
- Sleep outputs:
  - source_sleep_status = registered (state==IDLE).
  - o_source_sleep_ack = registered (state==IDLE && i_source_sleep_req).
- Writes carry no response.

## Timing
- Reset (async assert, sync release): state NORMAL, outstanding 0; o_rd_data 0, o_rd_valid 0, o_source_sleep_ack 0, source_sleep_status 0.
- Combinational outputs follow their equations during reset (state NORMAL, count 0).
- Request push: same cycle as acceptance, zero latency.
- Read return: o_rd_valid one cycle after rsp_fifo_rd_en.
- Sleep status/ack: high one cycle after entering IDLE; low one cycle after leaving IDLE.
- A request arriving in the same cycle as i_source_sleep_req is accepted, because the state is still NORMAL. It is then drained.
- Reset mid-transfer clears the counter. Stale FIFO contents are handled by the FIFO's own reset.

## Structure
- Shared bridge package: state encodings, packet field offsets (RW_BIT = packet_width-1, VALID_BIT = packet_width-2, ADDR_LSB = DATA_WIDTH), packet widths.
- Natural sub-module: outstanding_counter (up/down saturating-safe counter with zero and limit flags).

## Test plan
- **Write then read:** write 0x1000 ← 0xDEADBEEF, then read 0x1000; response FIFO supplies {1, 0xDEADBEEF} → packets 0x3_0000_1000_DEAD_BEEF and 0x1_0000_1000_0000_0000; o_rd_valid=1 with o_rd_data=0xDEADBEEF one cycle after the pop.
- **Outstanding limit:** issue 5 reads with MAX_OUTSTANDING=4 and the response FIFO empty → 4 accepted; o_ready low on the 5th until a response is popped.
- **FIFO full:** hold req_fifo_full=1 with i_valid=1 → o_ready=0 and req_fifo_wr_en=0; the request is accepted in the cycle full drops.
- **Sleep drain:** 2 reads outstanding, raise i_source_sleep_req → no new accepts; both responses returned; IDLE when the FIFOs are empty; status and ack high one cycle later; dropping the request returns the block to NORMAL with status 0 the next cycle.
- **Sink asleep:** sink_sleep_status=1 in NORMAL → o_ready=0, state stays NORMAL, pending responses still popped.
- **Reset mid-read:** assert i_rstn_source with 3 reads outstanding → all registered outputs 0, counter 0, state NORMAL.
